// File: rtl/store_buffer_pkg.sv
// Shared store-path definitions: byte-mask encodings and store-entry field widths
// used by the mask generator, the store buffer and the data-memory interface.
package store_buffer_pkg;
    localparam int SB_AW     = 30;
    localparam int SB_DATA_W = 32;
    localparam int SB_MASK_W = 4;

    localparam logic [SB_MASK_W-1:0] MASK_NONE = 4'b0000;
    localparam logic [SB_MASK_W-1:0] MASK_WORD = 4'b1111;
endpackage

// File: rtl/store_buffer_sb_match.sv
// DEPTH-way comparator: flags a load that overlaps any occupied store entry
// on the same word address with at least one common byte lane.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW
) (
    input  logic [AW-1:0]        ent_addr [DEPTH],
    input  logic [SB_MASK_W-1:0] ent_mask [DEPTH],
    input  logic [DEPTH-1:0]     occ,
    input  logic                 ld_valid,
    input  logic [AW-1:0]        ld_addr,
    input  logic [SB_MASK_W-1:0] ld_mask,
    output logic                 hit
);
    logic any_overlap;

    always_comb begin
        any_overlap = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (ent_addr[i] == ld_addr) &&
                ((ent_mask[i] & ld_mask) != MASK_NONE)) begin
                any_overlap = 1'b1;
            end
        end
    end

    assign hit = ld_valid && any_overlap;
endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: in-order FIFO of masked word stores drained to data
// memory over valid/ack, with load-overlap detection for the hazard unit.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [AW-1:0]              in_addr,
    input  logic [SB_DATA_W-1:0]       in_data,
    input  logic [SB_MASK_W-1:0]       in_mask,
    output logic                       in_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    input  logic [SB_MASK_W-1:0]       ld_mask,
    output logic                       ld_hit,
    input  logic                       fence,
    output logic                       fence_done,
    output logic                       mem_req,
    output logic [AW-1:0]              mem_addr,
    output logic [SB_DATA_W-1:0]       mem_wdata,
    output logic [SB_MASK_W-1:0]       mem_wmask,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [AW-1:0]        ent_addr_q [DEPTH];
    logic [AW-1:0]        ent_addr_d [DEPTH];
    logic [SB_DATA_W-1:0] ent_data_q [DEPTH];
    logic [SB_DATA_W-1:0] ent_data_d [DEPTH];
    logic [SB_MASK_W-1:0] ent_mask_q [DEPTH];
    logic [SB_MASK_W-1:0] ent_mask_d [DEPTH];
    logic [DEPTH-1:0]     occ;
    logic                 enq, deq;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign in_ready = !full;
    assign mem_req  = !empty;
    assign mem_addr  = ent_addr_q[rd_ptr_q];
    assign mem_wdata = ent_data_q[rd_ptr_q];
    assign mem_wmask = ent_mask_q[rd_ptr_q];
    assign fence_done = fence && empty;

    // A zero mask is accepted but never occupies a slot.
    assign enq = in_valid && in_ready && (in_mask != MASK_NONE);
    assign deq = mem_req && mem_ack;

    always_comb begin
        wr_ptr_d   = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_mask_d = ent_mask_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (enq) begin
            ent_addr_d[wr_ptr_q] = in_addr;
            ent_data_d[wr_ptr_q] = in_data;
            ent_mask_d[wr_ptr_q] = in_mask;
        end
    end

    // Slot i is occupied when its distance from the head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] off;
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off    = PTR_W'(i) - rd_ptr_q;
            occ[i] = ({1'b0, off} < count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_mask_q <= ent_mask_d;
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .ent_addr (ent_addr_q),
        .ent_mask (ent_mask_q),
        .occ      (occ),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_mask  (ld_mask),
        .hit      (ld_hit)
    );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4): reset, fill/overflow, streaming
// wrap, zero-mask drop, load hazard, fence drain and reset during a drain.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_data;
    logic [3:0]    in_mask;
    logic          in_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [3:0]    ld_mask;
    logic          ld_hit;
    logic          fence;
    logic          fence_done;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_ack;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask),
        .in_ready(in_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_hit(ld_hit),
        .fence(fence), .fence_done(fence_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
        in_valid = 1'b1; in_addr = a; in_data = d; in_mask = m;
        tick();
        in_valid = 1'b0; in_mask = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_addr = '0; in_data = '0; in_mask = '0;
        ld_valid = 0; ld_addr = '0; ld_mask = '0; fence = 0; mem_ack = 0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL reset_ld_hit got %b exp 0", ld_hit); end
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL reset_fence_done got %b exp 0", fence_done); end
    endtask

    task automatic test_zero_mask();
        push(30'h5, 32'hDEADBEEF, 4'b0000);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL zmask_count got %0d exp 0", count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zmask_mem_req got %b exp 0", mem_req); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_addr = 30'h10 + 30'(i); in_data = 32'hA0 + 32'(i);
            in_mask = (i == 0) ? 4'b0011 : 4'b1111;
            if (i == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
        checks++; if (mem_addr !== 30'h10) begin errors++; $display("FAIL fill_head_addr got %h exp 10", mem_addr); end
        checks++; if (mem_wmask !== 4'b0011) begin errors++; $display("FAIL fill_head_mask got %b exp 0011", mem_wmask); end
        checks++; if (mem_wdata !== 32'hA0) begin errors++; $display("FAIL fill_head_data got %h exp a0", mem_wdata); end
        // Full with ack: the offered store must be refused, only the dequeue happens.
        in_valid = 1'b1; in_addr = 30'h99; in_mask = 4'b1111; mem_ack = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ack_in_ready got %b exp 0", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_ack_count got %0d exp 3", count); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (mem_addr !== 30'h10 + 30'(i)) begin errors++; $display("FAIL drain_order got %h exp %h", mem_addr, 30'h10 + 30'(i)); end
            tick();
        end
        mem_ack = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_simul();
        push(30'h40, 32'h140, 4'b1111);
        push(30'h41, 32'h141, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_addr = 30'h42 + 30'(k); in_data = 32'h142 + 32'(k); in_mask = 4'b1111;
            mem_ack = 1'b1;
            checks++; if (mem_addr !== 30'h40 + 30'(k)) begin errors++; $display("FAIL simul_head got %h exp %h", mem_addr, 30'h40 + 30'(k)); end
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d exp 2", count); end
            tick();
        end
        in_valid = 1'b0; in_mask = 4'b0000;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count_end got %0d exp 2", count); end
        checks++; if (mem_addr !== 30'h45) begin errors++; $display("FAIL simul_wrap_head got %h exp 45", mem_addr); end
        tick();
        checks++; if (mem_addr !== 30'h46) begin errors++; $display("FAIL simul_wrap_last got %h exp 46", mem_addr); end
        checks++; if (mem_wdata !== 32'h146) begin errors++; $display("FAIL simul_wrap_data got %h exp 146", mem_wdata); end
        tick();
        mem_ack = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", empty); end
    endtask

    task automatic test_load_hazard();
        push(30'h20, 32'hCAFE0000, 4'b1100);
        ld_valid = 1'b1; ld_addr = 30'h20; ld_mask = 4'b0011; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_disjoint got %b exp 0", ld_hit); end
        ld_mask = 4'b0100; #1;
        checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL ld_overlap got %b exp 1", ld_hit); end
        ld_addr = 30'h21; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_other_addr got %b exp 0", ld_hit); end
        ld_addr = 30'h46; ld_mask = 4'b1111; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_stale_slot got %b exp 0", ld_hit); end
        ld_valid = 1'b0; ld_addr = 30'h20; ld_mask = 4'b0100; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_not_valid got %b exp 0", ld_hit); end
        ld_valid = 1'b1; mem_ack = 1'b1; #1;
        checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL ld_head_acking got %b exp 1", ld_hit); end
        tick();
        mem_ack = 1'b0;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_after_retire got %b exp 0", ld_hit); end
        in_valid = 1'b1; in_addr = 30'h30; in_data = 32'h3; in_mask = 4'b1111;
        ld_addr = 30'h30; ld_mask = 4'b1111; #1;
        checks++; if (ld_hit !== 1'b0) begin errors++; $display("FAIL ld_same_cycle got %b exp 0", ld_hit); end
        tick();
        in_valid = 1'b0; in_mask = 4'b0000;
        checks++; if (ld_hit !== 1'b1) begin errors++; $display("FAIL ld_next_cycle got %b exp 1", ld_hit); end
        ld_valid = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_fence();
        push(30'h50, 32'h50, 4'b0001);
        push(30'h51, 32'h51, 4'b0010);
        fence = 1'b1; mem_ack = 1'b1; #1;
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_c0 got %b exp 0", fence_done); end
        checks++; if (mem_addr !== 30'h50 || mem_wmask !== 4'b0001) begin errors++; $display("FAIL fence_order0 got %h/%b exp 50/0001", mem_addr, mem_wmask); end
        tick();
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_c1 got %b exp 0", fence_done); end
        checks++; if (mem_addr !== 30'h51 || mem_wmask !== 4'b0010) begin errors++; $display("FAIL fence_order1 got %h/%b exp 51/0010", mem_addr, mem_wmask); end
        tick();
        checks++; if (fence_done !== 1'b1) begin errors++; $display("FAIL fence_done got %b exp 1", fence_done); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ack_when_empty got %0d exp 0", count); end
        fence = 1'b0; mem_ack = 1'b0; #1;
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_low got %b exp 0", fence_done); end
    endtask

    task automatic test_reset_mid_drain();
        push(30'h60, 32'h60, 4'b1111);
        push(30'h61, 32'h61, 4'b1111);
        push(30'h62, 32'h62, 4'b1111);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmd_pre_count got %0d exp 3", count); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmd_count got %0d exp 0", count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmd_mem_req got %b exp 0", mem_req); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmd_in_ready got %b exp 1", in_ready); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (count !== 3'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL rmd_late_ack got %0d/%b exp 0/0", count, mem_req); end
        push(30'h70, 32'h70, 4'b1000);
        checks++; if (mem_addr !== 30'h70 || count !== 3'd1) begin errors++; $display("FAIL rmd_fresh_head got %h/%0d exp 70/1", mem_addr, count); end
    endtask

    initial begin
        test_reset();
        test_zero_mask();
        test_fill_overflow();
        test_simul();
        test_load_hazard();
        test_fence();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
